hist_scan_controller: RTL
=========================

HIST_SCAN_CONTROLLER -- requirements
Module: hist_scan_controller

Interface
REQ-001 SHALL have parameter BIN_W, default 16, histogram bin counter width.
REQ-002 SHALL have parameter ADDR_W, default 13, original-image pixel address width (8192 pixels).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  pulse that begins clear+scan; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminates any operation; return to IDLE.
REQ-007 SHALL have port pix_count  input  ADDR_W+1  number of pixels to scan; latched on accepted start.
REQ-008 SHALL have port img_addr  output  ADDR_W  original-image read address.
REQ-009 SHALL have port img_rdata  input  8  pixel value; valid one cycle after img_addr (registered-read memory).
REQ-010 SHALL have port bin_addr  output  8  histogram memory address.
REQ-011 SHALL have port bin_rdata  input  BIN_W  histogram memory asynchronous read data at bin_addr.
REQ-012 SHALL have port bin_wdata  output  BIN_W  histogram write data.
REQ-013 SHALL have port bin_we  output  1  histogram write enable, written at the rising edge.
REQ-014 SHALL have port busy  output  1  high in CLEAR, SCAN, DRAIN.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement states IDLE, CLEAR, SCAN, DRAIN, DONE.
REQ-017 IDLE: start=1 and abort=0 at an edge SHALL latch min(pix_count, 2^ADDR_W) as N, zero the clear counter, and enter CLEAR.
REQ-018 CLEAR: for 256 consecutive cycles SHALL drive bin_we=1, bin_wdata=0, bin_addr=0..255 ascending; after addr 255 enter SCAN if N>0, else DONE.
REQ-019 SCAN: SHALL drive img_addr=0..N-1, one address per cycle; after address N-1 is issued, enter DRAIN.
REQ-020 A pipeline valid flag SHALL mark the cycle after each issued address; in that cycle bin_addr=img_rdata, bin_we=1, bin_wdata=bin_rdata+1.
REQ-021 Increment SHALL saturate: if bin_rdata is all ones, bin_wdata SHALL equal bin_rdata.
REQ-022 Consecutive equal pixels SHALL count correctly without forwarding, because each read-modify-write completes in one cycle via asynchronous read.
REQ-023 DRAIN: SHALL perform the write for pixel N-1, then enter DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=0, bin_we=0; next state IDLE.
REQ-025 Cycle count: with start sampled at edge T, first clear write at T+1, first scan address at T+257, last bin write at T+257+N, done high in cycle T+258+N (T+257 when N=0).
REQ-026 start SHALL be ignored outside IDLE; pix_count changes after acceptance SHALL have no effect.
REQ-027 abort=1 SHALL force IDLE at the next edge from any state, with the pending pipelined write dropped and no done pulse; abort has priority over start.
REQ-028 bin_we SHALL be 0 in IDLE and DONE; img_addr SHALL hold its last value outside SCAN.
REQ-029 bin_addr, bin_wdata, and bin_we SHALL be combinational from registered state, counters, img_rdata, and bin_rdata only.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, with counters, N, and the valid flag at 0.
REQ-031 Outputs under reset SHALL be busy=0, done=0, bin_we=0, img_addr=0, bin_addr=0, bin_wdata=0.
REQ-032 Reset mid-operation SHALL discard all progress; the first edge after release with start=1 SHALL begin a fresh CLEAR.

Verification
REQ-033 Scenario, normal scan: N=4, pixels 5,5,5,7, start at T -> bins 5=3 and 7=1, all others 0; done only in cycle T+262; busy high T+1..T+261.
REQ-034 Scenario, zero pixels: N=0 with histogram memory prefilled 0xAAAA -> 256 zero writes, no img_addr change, done in cycle T+257.
REQ-035 Scenario, saturation: BIN_W=2, N=5, all pixels 9 -> bin 9=3, never wraps to 0.
REQ-036 Scenario, abort: abort asserted at scan address 2 of N=10 -> idle next edge, busy=0, no done, no further bin_we; a new start gives a correct full result.
REQ-037 Scenario, start while busy and clamping: start pulses during CLEAR and SCAN are ignored; pix_count=9000 clamps to 8192, last img_addr=8191.
REQ-038 Scenario, async reset: reset asserted mid-CLEAR at bin_addr 100 -> outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/hist_scan_controller.sv
// Histogram builder: clears a 256-bin memory, then scans N image pixels and
// increments the bin for each one with a single-cycle read-modify-write.
module hist_scan_controller #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   pix_count,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic [7:0]        bin_addr,
  input  logic [BIN_W-1:0]  bin_rdata,
  output logic [BIN_W-1:0]  bin_wdata,
  output logic              bin_we,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_PIX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        clr_q, clr_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic              busy_q, done_q;

  logic [CNT_W-1:0]  pix_clamped;
  logic              last_addr;

  assign pix_clamped = (pix_count > MAX_PIX) ? MAX_PIX : pix_count;
  assign last_addr   = ({1'b0, addr_q} == (n_q - CNT_W'(1)));

  // Next-state and counter update; abort overrides everything and drops the pending write.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    n_d     = n_q;
    addr_d  = addr_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = pix_clamped;
          clr_d   = 8'd0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_d = clr_q + 8'd1;
        if (clr_q == 8'hFF) begin
          if (n_q != '0) begin
            state_d = S_SCAN;
            addr_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SCAN: begin
        vld_d = 1'b1;
        if (last_addr) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      clr_q   <= 8'd0;
      n_q     <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_SCAN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Histogram port: clear writes, or increment of the bin addressed by the returning pixel.
  always_comb begin
    bin_we    = 1'b0;
    bin_addr  = 8'd0;
    bin_wdata = '0;
    if (state_q == S_CLEAR) begin
      bin_we   = 1'b1;
      bin_addr = clr_q;
    end else if (vld_q) begin
      bin_we    = 1'b1;
      bin_addr  = img_rdata;
      bin_wdata = (&bin_rdata) ? bin_rdata : bin_rdata + BIN_W'(1);
    end
  end

  assign img_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
